db_mv_ram_arb: RTL



---
 rtl/db_mv_ram_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/db_mv_ram_arb.sv
// db_mv_ram_arb: single-port access arbiter and 2-entry write buffer in front of the
// deblocking 64x20 motion-vector RAM. Reads win the RAM port. Buffered writes drain
// whenever no read is accepted. A full buffer blocks both request sides so that the
// head is forced out.
//
// Optional feature: define DB_MV_FWD_EN to forward buffered or same-cycle write data
// to a read of the same address.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_val_i/rdy_o  write handshake; wr_adr_i, wr_dat_i carry the write
//   rd_req_i/rdy_o  read handshake; rd_adr_i carries the read address
//   rd_val_o        read data valid, one cycle after acceptance
//   rd_dat_o        read data, zero when rd_val_o is low
//   ram_adr_o       RAM address
//   ram_cen_o       RAM chip enable, active low
//   ram_wen_o       RAM write enable, active low
//   ram_wr_dat_o    RAM write data
//   ram_rd_dat_i    RAM read data, valid the cycle after a read access
module db_mv_ram_arb #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_val_i,
  output logic          wr_rdy_o,
  input  logic [AW-1:0] wr_adr_i,
  input  logic [DW-1:0] wr_dat_i,
  input  logic          rd_req_i,
  output logic          rd_rdy_o,
  input  logic [AW-1:0] rd_adr_i,
  output logic          rd_val_o,
  output logic [DW-1:0] rd_dat_o,
  output logic [AW-1:0] ram_adr_o,
  output logic          ram_cen_o,
  output logic          ram_wen_o,
  output logic [DW-1:0] ram_wr_dat_o,
  input  logic [DW-1:0] ram_rd_dat_i
);

  // Slot 0 is always the FIFO head, slot 1 the newer entry.
  logic [AW-1:0] adr_q [2];
  logic [AW-1:0] adr_d [2];
  logic [DW-1:0] dat_q [2];
  logic [DW-1:0] dat_d [2];
  logic [1:0]    cnt_q, cnt_d;
  logic          rd_val_q;

  logic rd_acc;
  logic wr_acc;
  logic pop;

  assign wr_rdy_o = (cnt_q != 2'd2);
  assign rd_rdy_o = (cnt_q != 2'd2);
  assign rd_acc   = rd_req_i & rd_rdy_o;
  assign wr_acc   = wr_val_i & wr_rdy_o;
  assign pop      = ~rd_acc & (cnt_q != 2'd0);
  assign rd_val_o = rd_val_q;

  // FIFO next state. A push never coincides with cnt == 2, so push-with-pop only
  // happens at cnt == 1 and the new entry lands in the freshly vacated head.
  always_comb begin
    adr_d = adr_q;
    dat_d = dat_q;
    cnt_d = cnt_q;
    if (pop) begin
      adr_d[0] = adr_q[1];
      dat_d[0] = dat_q[1];
      adr_d[1] = '0;
      dat_d[1] = '0;
    end
    if (wr_acc) begin
      if (pop || (cnt_q == 2'd0)) begin
        adr_d[0] = wr_adr_i;
        dat_d[0] = wr_dat_i;
      end else begin
        adr_d[1] = wr_adr_i;
        dat_d[1] = wr_dat_i;
      end
    end
    unique case ({wr_acc, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 2'd0;
      rd_val_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        adr_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      rd_val_q <= rd_acc;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
    end
  end

  // RAM port selection; held idle while reset is asserted.
  always_comb begin
    ram_cen_o    = 1'b1;
    ram_wen_o    = 1'b1;
    ram_adr_o    = '0;
    ram_wr_dat_o = '0;
    if (rst_n) begin
      if (rd_acc) begin
        ram_cen_o = 1'b0;
        ram_adr_o = rd_adr_i;
      end else if (cnt_q != 2'd0) begin
        ram_cen_o    = 1'b0;
        ram_wen_o    = 1'b0;
        ram_adr_o    = adr_q[0];
        ram_wr_dat_o = dat_q[0];
      end
    end
  end

`ifdef DB_MV_FWD_EN
  logic          fwd_hit_q, fwd_hit_d;
  logic [DW-1:0] fwd_dat_q, fwd_dat_d;

  // Newest data wins: incoming write, then newer slot, then head.
  always_comb begin
    fwd_hit_d = 1'b0;
    fwd_dat_d = '0;
    if (rd_acc) begin
      if (wr_acc && (wr_adr_i == rd_adr_i)) begin
        fwd_hit_d = 1'b1;
        fwd_dat_d = wr_dat_i;
      end else if ((cnt_q == 2'd2) && (adr_q[1] == rd_adr_i)) begin
        fwd_hit_d = 1'b1;
        fwd_dat_d = dat_q[1];
      end else if ((cnt_q != 2'd0) && (adr_q[0] == rd_adr_i)) begin
        fwd_hit_d = 1'b1;
        fwd_dat_d = dat_q[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_q <= 1'b0;
      fwd_dat_q <= '0;
    end else begin
      fwd_hit_q <= fwd_hit_d;
      fwd_dat_q <= fwd_dat_d;
    end
  end

  always_comb begin
    rd_dat_o = '0;
    if (rd_val_q) begin
      rd_dat_o = fwd_hit_q ? fwd_dat_q : ram_rd_dat_i;
    end
  end
`else
  // No forwarding: the upstream stage guarantees read-after-write ordering.
  always_comb begin
    rd_dat_o = '0;
    if (rd_val_q) begin
      rd_dat_o = ram_rd_dat_i;
    end
  end
`endif

endmodule
